// File: rtl/clock_phase_selector.sv
// Clock polarity calibration: measures err for invert=0 and invert=1, keeps the cleaner polarity.
// Optional CLOCK_PHASE_AUTORECAL_EN: while locked in HOLD, a bad rolling window triggers recalibration.
module clock_phase_selector #(
    parameter int unsigned WINDOW_LOG2   = 10,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned ERR_WIDTH     = 12,
    parameter int unsigned ERR_THRESHOLD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 err,
    output logic                 invert,
    output logic                 busy,
    output logic                 done,
    output logic                 locked,
    output logic                 fail,
    output logic [ERR_WIDTH-1:0] err_cnt0,
    output logic [ERR_WIDTH-1:0] err_cnt1
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [WINDOW_LOG2:0] WIN_LAST = {1'b0, {WINDOW_LOG2{1'b1}}};
    localparam logic [ERR_WIDTH:0] THR = (ERR_WIDTH + 1)'(ERR_THRESHOLD);

    typedef enum logic [3:0] {
        S_IDLE, S_SETTLE0, S_MEAS0, S_SETTLE1, S_MEAS1,
        S_DECIDE, S_SETTLE_F, S_DONE, S_HOLD
    } state_t;

    state_t state, state_nxt;

    logic [SETTLE_W-1:0]  settle_cnt;
    logic [WINDOW_LOG2:0] win_cnt;
    logic                 settle_last;
    logic                 win_last;
    logic                 in_settle;
    logic                 in_meas;
    logic                 restart;
    logic                 hold_roll;
    logic                 auto_restart;
    logic [ERR_WIDTH-1:0] sel_cnt;

    function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v, input logic e);
        return (e && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_comb begin
        settle_last = (settle_cnt == SETTLE_LAST);
        win_last    = (win_cnt == WIN_LAST);
        in_settle   = (state == S_SETTLE0) || (state == S_SETTLE1) || (state == S_SETTLE_F);
        in_meas     = (state == S_MEAS0) || (state == S_MEAS1);
        busy        = (state != S_IDLE) && (state != S_HOLD);
        done        = (state == S_DONE);
        sel_cnt     = invert ? err_cnt1 : err_cnt0;
    end

`ifdef CLOCK_PHASE_AUTORECAL_EN
    logic [ERR_WIDTH-1:0] roll_cnt;
    logic [ERR_WIDTH-1:0] roll_nxt;

    always_comb begin
        hold_roll    = (state == S_HOLD) && locked;
        roll_nxt     = sat_inc(roll_cnt, err);
        auto_restart = hold_roll && win_last && ({1'b0, roll_nxt} > THR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            roll_cnt <= '0;
        end else if (hold_roll && !win_last) begin
            roll_cnt <= roll_nxt;
        end else begin
            roll_cnt <= '0;
        end
    end
`else
    always_comb begin
        hold_roll    = 1'b0;
        auto_restart = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        case (state)
            S_IDLE:     restart = start;
            S_SETTLE0:  if (settle_last) state_nxt = S_MEAS0;
            S_MEAS0:    if (win_last) state_nxt = S_SETTLE1;
            S_SETTLE1:  if (settle_last) state_nxt = S_MEAS1;
            S_MEAS1:    if (win_last) state_nxt = S_DECIDE;
            S_DECIDE:   state_nxt = S_SETTLE_F;
            S_SETTLE_F: if (settle_last) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_HOLD;
            S_HOLD:     restart = start || auto_restart;
            default:    state_nxt = S_IDLE;
        endcase
        if (restart) begin
            state_nxt = S_SETTLE0;
        end
    end

    // Counters clear on every state change so each phase starts counting from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            win_cnt    <= '0;
        end else if (state_nxt != state) begin
            settle_cnt <= '0;
            win_cnt    <= '0;
        end else begin
            if (in_settle) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (in_meas || hold_roll) begin
                win_cnt <= win_last ? '0 : win_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            invert   <= 1'b0;
            locked   <= 1'b0;
            fail     <= 1'b0;
            err_cnt0 <= '0;
            err_cnt1 <= '0;
        end else if (restart) begin
            invert   <= 1'b0;
            locked   <= 1'b0;
            fail     <= 1'b0;
            err_cnt0 <= '0;
            err_cnt1 <= '0;
        end else begin
            case (state)
                S_MEAS0: begin
                    err_cnt0 <= sat_inc(err_cnt0, err);
                    if (win_last) begin
                        invert <= 1'b1;
                    end
                end
                S_MEAS1:  err_cnt1 <= sat_inc(err_cnt1, err);
                S_DECIDE: invert <= (err_cnt1 < err_cnt0);
                S_DONE: begin
                    locked <= ({1'b0, sel_cnt} <= THR);
                    fail   <= !({1'b0, sel_cnt} <= THR);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_phase_selector.sv
// Scoreboard bench for clock_phase_selector: stimulus pushes expected decisions, monitors check on done.
module tb_clock_phase_selector;

    localparam int W   = 6;
    localparam int S   = 8;
    localparam int N   = 1 << W;
    localparam int LAT = 3 * S + 2 * N + 3;

    typedef struct {
        int     c0;
        int     c1;
        int     inv;
        int     lk;
        int     fl;
        longint t0;
        bit     chk_lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        err_a = 1'b0, err_b = 1'b0;
    logic [1:0]  inv_s, busy_s, done_s, lk_s, fl_s;
    logic [11:0] c0a, c1a;
    logic [3:0]  c0b, c1b;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    exp_t   q0[$];
    exp_t   q1[$];

    clock_phase_selector #(
        .WINDOW_LOG2(W), .SETTLE_CYCLES(S), .ERR_WIDTH(12), .ERR_THRESHOLD(0)
    ) dut (
        .clk(clk), .rst(rst_a), .start(start_a), .err(err_a),
        .invert(inv_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .locked(lk_s[0]), .fail(fl_s[0]), .err_cnt0(c0a), .err_cnt1(c1a)
    );

    clock_phase_selector #(
        .WINDOW_LOG2(W), .SETTLE_CYCLES(S), .ERR_WIDTH(4), .ERR_THRESHOLD(5)
    ) dut_sat (
        .clk(clk), .rst(rst_b), .start(start_b), .err(err_b),
        .invert(inv_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .locked(lk_s[1]), .fail(fl_s[1]), .err_cnt0(c0b), .err_cnt1(c1b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic on_done(input int idx);
        exp_t e;
        int   c0, c1, lat;
        if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
            chk($sformatf("unexpected_done%0d", idx), 1, 0);
            return;
        end
        e   = (idx == 0) ? q0.pop_front() : q1.pop_front();
        c0  = (idx == 0) ? int'(c0a) : int'(c0b);
        c1  = (idx == 0) ? int'(c1a) : int'(c1b);
        lat = int'(cyc - e.t0);
        chk($sformatf("err_cnt0_%0d", idx), c0, e.c0);
        chk($sformatf("err_cnt1_%0d", idx), c1, e.c1);
        chk($sformatf("invert_%0d", idx), int'(inv_s[idx]), e.inv);
        if (e.chk_lat) begin
            chk($sformatf("latency_%0d_within_2_of_%0d(actual=%0d)", idx, LAT, lat),
                int'(lat >= LAT - 2 && lat <= LAT + 2), 1);
        end
        @(negedge clk);
        chk($sformatf("locked_%0d", idx), int'(lk_s[idx]), e.lk);
        chk($sformatf("fail_%0d", idx), int'(fl_s[idx]), e.fl);
        chk($sformatf("busy_after_done_%0d", idx), int'(busy_s[idx]), 0);
        chk($sformatf("done_one_cycle_%0d", idx), int'(done_s[idx]), 0);
    endtask

    initial forever begin
        @(negedge clk);
        if (done_s[0]) on_done(0);
    end

    initial forever begin
        @(negedge clk);
        if (done_s[1]) on_done(1);
    end

    // err_a is high for j in [lo1,hi1] or [lo2,hi2], j counted in cycles after the start edge.
    task automatic run_a(input int lo1, input int hi1, input int lo2, input int hi2,
                         input int restart_j, input int e0, input int e1, input int einv,
                         input int elk, input int efl);
        exp_t e;
        e.c0 = e0; e.c1 = e1; e.inv = einv; e.lk = elk; e.fl = efl; e.chk_lat = 1'b1;
        @(negedge clk);
        start_a = 1'b1;
        e.t0 = cyc;
        q0.push_back(e);
        for (int j = 0; j < 3 * S + 2 * N + 8; j++) begin
            @(negedge clk);
            start_a = (j == restart_j);
            err_a   = (j >= lo1 && j <= hi1) || (j >= lo2 && j <= hi2);
            if (j == 0)     chk("busy_after_start", int'(busy_s[0]), 1);
            if (j == S + N - 1) chk("invert_last_meas0", int'(inv_s[0]), 0);
            if (j == S + N) chk("invert_first_settle1", int'(inv_s[0]), 1);
        end
        err_a   = 1'b0;
        start_a = 1'b0;
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (100) @(negedge clk);
        chk("reset_invert", int'(inv_s[0]), 0);
        chk("reset_busy", int'(busy_s[0]), 0);
        chk("reset_locked", int'(lk_s[0]), 0);
        chk("reset_fail", int'(fl_s[0]), 0);
        chk("reset_cnt0", int'(c0a), 0);
        chk("reset_cnt1", int'(c1a), 0);

        // invert=1 side dirty, including the last SETTLE1 cycle which must not count
        run_a(S + N, 2 * S + 2 * N - 1, -1, -1, -1, 0, N, 0, 1, 0);
        // 10 errors ending on the last MEAS0 cycle, plus one in the last SETTLE0 cycle
        run_a(S + N - 10, S + N - 1, S - 1, S - 1, -1, 10, 0, 1, 1, 0);
        // clean run with a second start while busy
        run_a(-1, -1, -1, -1, 50, 0, 0, 0, 1, 0);

        // saturating instance: err always high, tie at 15 with threshold 5
        e.c0 = 15; e.c1 = 15; e.inv = 0; e.lk = 0; e.fl = 1; e.chk_lat = 1'b1;
        @(negedge clk);
        start_b = 1'b1;
        err_b   = 1'b1;
        e.t0 = cyc;
        q1.push_back(e);
        for (int j = 0; j < 3 * S + 2 * N + 8; j++) begin
            @(negedge clk);
            start_b = 1'b0;
        end
        repeat (2 * N + 4) @(negedge clk);
        chk("fail_hold_no_restart", int'(busy_s[1]), 0);

        start_b = 1'b1;
        for (int j = 0; j < 2 * S + N + 10; j++) begin
            @(negedge clk);
            start_b = 1'b0;
        end
        chk("busy_before_abort", int'(busy_s[1]), 1);
        rst_b = 1'b1;
        #1;
        chk("abort_invert", int'(inv_s[1]), 0);
        chk("abort_busy", int'(busy_s[1]), 0);
        chk("abort_cnt0", int'(c0b), 0);
        chk("abort_cnt1", int'(c1b), 0);
        chk("abort_fail", int'(fl_s[1]), 0);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        err_b = 1'b0;
        repeat (3 * S + 2 * N + 8) @(negedge clk);
        chk("abort_stays_idle", int'(busy_s[1]), 0);

`ifdef CLOCK_PHASE_AUTORECAL_EN
        begin
            int got;
            e.c0 = 0; e.c1 = 0; e.inv = 0; e.lk = 1; e.fl = 0; e.chk_lat = 1'b0; e.t0 = cyc;
            q0.push_back(e);
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                err_a = (k % 2 == 0);
            end
            @(negedge clk);
            err_a = 1'b0;
            got = 0;
            for (int k = 0; k < 2 * N + 4 && got == 0; k++) begin
                @(negedge clk);
                if (busy_s[0]) got = 1;
            end
            chk("autorecal_busy", got, 1);
            chk("autorecal_locked_cleared", int'(lk_s[0]), 0);
            repeat (3 * S + 2 * N + 8) @(negedge clk);
        end
`endif

        repeat (4) @(negedge clk);
        chk("pending_expect_a", q0.size(), 0);
        chk("pending_expect_b", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
